// File: rtl/mips_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  localparam int ITER = 32;

endpackage

// File: rtl/mips_seq_divider.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step.
module mips_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = (shifted >= {1'b0, dvs});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mips_hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33-cycle busy window per op.
module mips_hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state, state_nx;
  muldiv_op_t       op_q;
  logic [4:0]       cnt;
  logic             sign_a, sign_b, b_zero;
  logic [WIDTH-1:0] a_raw, mcand, mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH:0]   sum;
  logic             in_signed, is_div_q, neg_res;

  always_comb begin
    in_signed = ~op[0];
    mag_a     = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b     = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    neg_res   = sign_a ^ sign_b;
    sum       = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                        : {1'b0, prod[2*WIDTH-1:WIDTH]};
    prod_fix  = neg_res ? -prod : prod;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  mips_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == S_IDLE) && start),
    .step      (state == S_CALC),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= OP_MULT;
      cnt         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      mcand       <= '0;
      prod        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= state_nx;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start in IDLE swallows any simultaneous MTHI/MTLO.
          if (start) begin
            op_q   <= muldiv_op_t'(op);
            cnt    <= 5'(ITER - 1);
            sign_a <= in_signed & operand_a[WIDTH-1];
            sign_b <= in_signed & operand_b[WIDTH-1];
            b_zero <= (operand_b == '0);
            a_raw  <= operand_a;
            mcand  <= mag_a;
            prod   <= {{WIDTH{1'b0}}, mag_b};
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        S_CALC: begin
          cnt  <= cnt - 5'd1;
          prod <= {sum, prod[WIDTH-1:1]};
        end
        S_FIX: begin
          done <= 1'b1;
          if (!is_div_q) begin
            {hi, lo} <= prod_fix;
          end else if (b_zero) begin
            hi          <= a_raw;
            lo          <= DIV0_LO;
            div_by_zero <= 1'b1;
          end else begin
            lo <= neg_res ? -quo : quo;
            hi <= sign_a ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Directed bench for mips_hilo_muldiv: arithmetic, busy profile, MTHI/MTLO priority, reset abort.
module tb_mips_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, mt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  mips_hilo_muldiv #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .mt_data     (mt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles until busy drops, bounded at 100.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int c;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c);
    check({tag, "_busy_cycles"}, 32'(c), 32'd33);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; operand_a = '0; operand_b = '0; mt_data = '0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    run_op("mult_neg", 2'b00, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFCF, 1'b0);
    // Issued in the done cycle of the previous op: back-to-back.
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_pos_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("mult_zero", 2'b00, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    check("dbz_one_pulse", {31'b0, div_by_zero}, 32'd0);
    check("done_one_pulse", {31'b0, done}, 32'd0);

    // MTLO alone, then MTHI+MTLO together.
    mtlo = 1'b1; mt_data = 32'h1234;
    tick();
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi_kept", hi, 32'd0);
    check("mtlo_no_done", {31'b0, done}, 32'd0);
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h5A5A_0001;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", hi, 32'h5A5A_0001);
    check("mtboth_lo", lo, 32'h5A5A_0001);

    // Start with MTLO in the same cycle: MTLO dropped, LO held through CALC.
    op = 2'b01; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("start_wins_lo", lo, 32'h5A5A_0001);
    check("start_busy", {31'b0, busy}, 32'd1);
    repeat (5) tick();
    mthi = 1'b1; start = 1'b1; op = 2'b10; operand_a = 32'd1; operand_b = 32'd1;
    mt_data = 32'hCAFE_F00D;
    tick();
    mthi = 1'b0; start = 1'b0;
    check("calc_hi_held", hi, 32'h5A5A_0001);
    check("calc_lo_held", lo, 32'h5A5A_0001);
    wait_done(n);
    check("seq_busy_rest", 32'(n), 32'd27);
    check("seq_done", {31'b0, done}, 32'd1);
    check("seq_hi", hi, 32'd0);
    check("seq_lo", lo, 32'd15);
    run_op("b2b_divu", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);

    // Reset during CALC aborts with no done pulse.
    op = 2'b00; operand_a = 32'd11; operand_b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) begin
      tick();
      if (done === 1'b1) begin
        check("abort_late_done", {31'b0, done}, 32'd0);
      end
    end
    run_op("post_abort_divu", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
